// File: rtl/tiny_fpga_cfg_sequencer.sv
// tiny_fpga_cfg_sequencer: byte-wide host bitstream to 1-bit fabric
// config stream, LSB first, with cfg/run sequencing for tiny_fpga.
// Ports: clk, rst (sync, active-high), start;
//   s_tvalid/s_tready/s_tdata[7:0]/s_tlast  host byte stream;
//   fab_tvalid/fab_tready/fab_tdata/fab_tlast  fabric bit stream;
//   fab_cfg, fab_cfg_ready, fab_run  fabric mode control;
//   busy, err  status (err sticky until start or rst).
// Optional: define CFG_TIMEOUT_EN for the cfg_ready watchdog.
module tiny_fpga_cfg_sequencer #(
  parameter int EXPECTED_BITS  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  output logic       fab_tvalid,
  input  logic       fab_tready,
  output logic       fab_tdata,
  output logic       fab_tlast,
  output logic       fab_cfg,
  input  logic       fab_cfg_ready,
  output logic       fab_run,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(EXPECTED_BITS + 1);
  localparam logic [CW-1:0] EXP_CNT = CW'(EXPECTED_BITS);

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    SHIFT,
    WAIT_RDY,
    RUN,
    ERROR
  } state_t;

  state_t state;
  state_t nxt;

  logic          holding;
  logic          last_flag;
  logic [7:0]    sr;
  logic [2:0]    bit_idx;
  logic [CW-1:0] bit_cnt;

  logic          hold_d;
  logic          last_d;
  logic [7:0]    sr_d;
  logic [2:0]    idx_d;
  logic [CW-1:0] cnt_d;

  logic          fab_hs;
  logic          host_hs;
  logic [CW-1:0] cnt_inc;
  logic          to_hit;

  logic cfg_d;
  logic run_d;
  logic busy_d;
  logic err_d;

  assign fab_tvalid = holding;
  assign fab_tdata  = sr[0];

  assign fab_hs  = (state == SHIFT) && holding && fab_tready;
  assign cnt_inc = bit_cnt + 1'b1;

  // A new byte may land in the same cycle the current byte's
  // final bit leaves, so a continuous stream has no bubble.
  assign s_tready = (state == SHIFT) &&
                    (!holding ||
                     (bit_idx == 3'd7 && fab_tready && !last_flag));

  assign host_hs = s_tvalid && s_tready;

`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RDY) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_to;

  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fab_cfg <= 1'b0;
      fab_run <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      fab_cfg <= cfg_d;
      fab_run <= run_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = ENTER;
      end
      ENTER: begin
        nxt = SHIFT;
      end
      SHIFT: begin
        if (fab_hs) begin
          if (fab_tlast) begin
            nxt = (cnt_inc == EXP_CNT) ? WAIT_RDY : ERROR;
          end else if (cnt_inc == EXP_CNT) begin
            nxt = ERROR;
          end
        end
      end
      WAIT_RDY: begin
        if (fab_cfg_ready) begin
          nxt = RUN;
        end else if (to_hit) begin
          nxt = ERROR;
        end
      end
      RUN, ERROR: begin
        if (start) nxt = ENTER;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change
  // on the same edge as the transition.
  always_comb begin
    cfg_d  = (nxt == ENTER) || (nxt == SHIFT) ||
             (nxt == WAIT_RDY);
    busy_d = cfg_d;
    run_d  = (nxt == RUN);
    err_d  = (nxt == ERROR);
  end

  // Serializer state is wiped whenever SHIFT is not the next
  // state, so every load starts from a clean slate.
  always_comb begin
    hold_d = holding;
    last_d = last_flag;
    sr_d   = sr;
    idx_d  = bit_idx;
    cnt_d  = bit_cnt;
    if (nxt != SHIFT) begin
      hold_d = 1'b0;
      last_d = 1'b0;
      sr_d   = '0;
      idx_d  = '0;
      cnt_d  = '0;
    end else begin
      if (fab_hs) begin
        sr_d  = {1'b0, sr[7:1]};
        idx_d = bit_idx + 3'd1;
        cnt_d = cnt_inc;
        if (bit_idx == 3'd7) hold_d = 1'b0;
      end
      if (host_hs) begin
        sr_d   = s_tdata;
        idx_d  = '0;
        last_d = s_tlast;
        hold_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holding   <= 1'b0;
      last_flag <= 1'b0;
      sr        <= '0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      fab_tlast <= 1'b0;
    end else begin
      holding   <= hold_d;
      last_flag <= last_d;
      sr        <= sr_d;
      bit_idx   <= idx_d;
      bit_cnt   <= cnt_d;
      fab_tlast <= hold_d && last_d && (idx_d == 3'd7);
    end
  end

endmodule

// File: tb/tb_tiny_fpga_cfg_sequencer.sv
// Bench for tiny_fpga_cfg_sequencer: directed plus random loads
// checked against a byte-list model of the expected bit stream.
module tb_tiny_fpga_cfg_sequencer;

  localparam int EXP = 16;
  localparam int TO  = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       fab_tvalid;
  logic       fab_tready;
  logic       fab_tdata;
  logic       fab_tlast;
  logic       fab_cfg;
  logic       fab_cfg_ready;
  logic       fab_run;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  bytes [3];
  logic [23:0] rx;
  int          span;
  int          nb;
  int          n;
  int          cyc;

  tiny_fpga_cfg_sequencer #(
    .EXPECTED_BITS (EXP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .fab_tvalid   (fab_tvalid),
    .fab_tready   (fab_tready),
    .fab_tdata    (fab_tdata),
    .fab_tlast    (fab_tlast),
    .fab_cfg      (fab_cfg),
    .fab_cfg_ready(fab_cfg_ready),
    .fab_run      (fab_run),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_cfg", fab_cfg, 1);
    chk("start_run", fab_run, 0);
    chk("start_err", err, 0);
    chk("start_busy", busy, 1);
    chk("start_srdy", s_tready, 0);
    chk("start_tvalid", fab_tvalid, 0);
  endtask

  task automatic go_run;
    fab_cfg_ready = 1'b1;
    @(negedge clk);
    fab_cfg_ready = 1'b0;
    chk("run_run", fab_run, 1);
    chk("run_cfg", fab_cfg, 0);
    chk("run_busy", busy, 0);
  endtask

  task automatic post(input bit ok);
    chk("post_cfg", fab_cfg, ok);
    chk("post_busy", busy, ok);
    chk("post_err", err, !ok);
    chk("post_run", fab_run, 0);
    chk("post_tvalid", fab_tvalid, 0);
    chk("post_tlast", fab_tlast, 0);
  endtask

  // mode 0: always ready/valid, 1: fab_tready toggles,
  // 2: random ready and valid
  task automatic load(input int nbytes, input int mode,
                      output logic [23:0] rxo,
                      output int spn);
    int k;
    int hi;
    int c;
    int first;
    int lastc;
    int nsend;
    logic pst;
    logic pd;
    logic pl;
    logic tr;
    logic tv;
    logic [7:0] b;
    k = 0;
    hi = 0;
    c = 0;
    first = -1;
    lastc = 0;
    pst = 1'b0;
    pd = 1'b0;
    pl = 1'b0;
    rxo = '0;
    nsend = (nbytes * 8 < EXP) ? nbytes * 8 : EXP;
    while (k < nsend && c < 300) begin
      if (pst) begin
        chk("stall_valid", fab_tvalid, 1);
        chk("stall_data", fab_tdata, pd);
        chk("stall_last", fab_tlast, pl);
      end
      if (fab_tvalid && first < 0) first = c;
      case (mode)
        0: begin tr = 1'b1; tv = 1'b1; end
        1: begin tr = (c % 2 == 0); tv = 1'b1; end
        default: begin
          tr = ($urandom_range(0, 3) != 0);
          tv = ($urandom_range(0, 3) != 0);
        end
      endcase
      fab_tready = tr;
      s_tvalid   = tv && (hi < nbytes);
      s_tdata    = (hi < nbytes) ? bytes[hi] : 8'h00;
      s_tlast    = (hi == nbytes - 1);
      #1;
      if (s_tvalid && s_tready) hi++;
      if (fab_tvalid && fab_tready) begin
        b = bytes[k / 8];
        chk("bit_data", fab_tdata, b[k % 8]);
        chk("bit_last", fab_tlast, (k == nbytes * 8 - 1));
        rxo[k] = fab_tdata;
        k++;
        lastc = c;
      end
      pst = fab_tvalid && !fab_tready;
      pd  = fab_tdata;
      pl  = fab_tlast;
      @(negedge clk);
      c++;
    end
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    fab_tready = 1'b0;
    chk("load_done", k, nsend);
    spn = lastc - first + 1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = 8'h00;
    s_tlast = 1'b0;
    fab_tready = 1'b0;
    fab_cfg_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg", fab_cfg, 0);
    chk("rst_run", fab_run, 0);
    chk("rst_tvalid", fab_tvalid, 0);
    chk("rst_tdata", fab_tdata, 0);
    chk("rst_tlast", fab_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_srdy", s_tready, 0);
    rst = 1'b0;
    @(negedge clk);

    fab_cfg_ready = 1'b1;
    repeat (2) @(negedge clk);
    fab_cfg_ready = 1'b0;
    chk("idle_ign_run", fab_run, 0);
    chk("idle_ign_cfg", fab_cfg, 0);

    // nominal load
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    do_start;
    load(2, 0, rx, span);
    chk("nom_bits", rx[15:0], 16'h3CA5);
    chk("nom_span", span, 16);
    post(1'b1);
    chk("wait_srdy", s_tready, 0);
    go_run;

    // reconfigure from RUN under backpressure
    bytes[0] = 8'($urandom);
    bytes[1] = 8'($urandom);
    do_start;
    load(2, 1, rx, span);
    chk("bp_bits", rx[15:0], {bytes[1], bytes[0]});
    chk("bp_span", span <= 32, 1);
    post(1'b1);
    go_run;

    // length error then recovery
    bytes[0] = 8'($urandom);
    do_start;
    load(1, 0, rx, span);
    post(1'b0);
    do_start;
    bytes[0] = 8'($urandom);
    bytes[1] = 8'($urandom);
    load(2, 0, rx, span);
    post(1'b1);
    go_run;

    // random loads
    for (int i = 0; i < 8; i++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < 3; j++) bytes[j] = 8'($urandom);
      do_start;
      load(nb, 2, rx, span);
      post(nb * 8 == EXP);
      if (nb * 8 == EXP) go_run;
    end

    // reset after 5 bits
    do_start;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 50) begin
      fab_tready = 1'b1;
      s_tvalid = 1'b1;
      s_tdata = 8'hA5;
      s_tlast = 1'b0;
      #1;
      if (fab_tvalid && fab_tready) n++;
      @(negedge clk);
      cyc++;
    end
    chk("mid_bits", n, 5);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cfg", fab_cfg, 0);
    chk("mid_run", fab_run, 0);
    chk("mid_tvalid", fab_tvalid, 0);
    chk("mid_tdata", fab_tdata, 0);
    chk("mid_tlast", fab_tlast, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    chk("mid_srdy", s_tready, 0);
    rst = 1'b0;
    fab_tready = 1'b0;
    fab_cfg_ready = 1'b1;
    repeat (3) @(negedge clk);
    fab_cfg_ready = 1'b0;
    chk("mid_ign_run", fab_run, 0);
    chk("mid_ign_cfg", fab_cfg, 0);

    // cfg_ready watchdog
    bytes[0] = 8'($urandom);
    bytes[1] = 8'($urandom);
    do_start;
    load(2, 0, rx, span);
    post(1'b1);
`ifdef CFG_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("to_before", err, 0);
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_cfg", fab_cfg, 0);
`else
    repeat (100) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_cfg", fab_cfg, 1);
    chk("nto_err", err, 0);
    go_run;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tiny_fpga_cfg_sequencer.md
# tiny_fpga_cfg_sequencer

Configuration and run-mode sequencer in front of the tiny FPGA fabric. Accepts the bitstream as a byte-wide stream from the host side and serializes it LSB-first onto the fabric's 1-bit AXI-stream configuration port. Drives the fabric `cfg` and `run` controls in the required order: enter config, stream, wait for `cfg_ready`, then run. Sits between the host interface logic and `tiny_fpga`.

## Interface

Parameters:
- `EXPECTED_BITS`, default 64: required total bitstream length in bits; must be a multiple of 8.
- `TIMEOUT_CYCLES`, default 1024: `cfg_ready` watchdog limit in cycles; used only with `CFG_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request; begin (re)configuration.
- `s_tvalid` in 1: host byte valid.
- `s_tready` out 1: host byte ready.
- `s_tdata` in 8: bitstream byte; bit 0 is sent first.
- `s_tlast` in 1: marks the final byte.
- `fab_tvalid` out 1: fabric bitstream valid.
- `fab_tready` in 1: fabric bitstream ready.
- `fab_tdata` out 1: bitstream bit.
- `fab_tlast` out 1: final bit of the bitstream.
- `fab_cfg` out 1: fabric configuration mode.
- `fab_cfg_ready` in 1: fabric reports configuration complete.
- `fab_run` out 1: fabric run enable.
- `busy` out 1: high in every state except IDLE, RUN and ERROR.
- `err` out 1: sticky error flag; cleared by `start` or `rst`.

## Operation

States:
- **IDLE**: `fab_cfg=0`, `fab_run=0`. Goes to ENTER on `start`.
- **ENTER**: lasts one cycle with `fab_cfg=1` and nothing streamed, so the fabric sees config mode before the first bit. Always goes to SHIFT.
- **SHIFT**: holds an 8-bit shift register, a 3-bit bit index and a last flag.
  - `s_tready = holding==0 || (bit_idx==7 && fab_tready && !last_flag)`.
  - When `holding==1`, `fab_tvalid=1` and `fab_tdata=sr[0]`.
  - `fab_tlast=1` when `last_flag && bit_idx==7`.
  - Each fabric handshake shifts `sr` right, increments `bit_idx` (wrapping 7→0) and increments a bit counter sized `$clog2(EXPECTED_BITS+1)` bits.
  - After the handshake with `fab_tlast=1`: if the counter equals `EXPECTED_BITS`, go to WAIT_READY; otherwise set `err` and go to ERROR.
  - If the counter reaches `EXPECTED_BITS` without `fab_tlast`, that is also an error.
- **WAIT_READY**: `fab_cfg=1`, no streaming, `s_tready=0`. `fab_cfg_ready=1` → RUN.
- **RUN**: `fab_cfg=0`, `fab_run=1`. `start` → ENTER, and `fab_run` drops in that same transition.
- **ERROR**: `fab_cfg=0`, `fab_run=0`, `err=1`. `start` → ENTER and clears `err`.
- `start` in SHIFT or WAIT_READY is ignored.
- `s_tready=0` in every state except SHIFT.

## Timing

- All outputs are registered, except `s_tready`, which is combinational from registered state and `fab_tready`.
- Values after `rst`: state IDLE, `fab_cfg=0`, `fab_run=0`, `fab_tvalid=0`, `fab_tdata=0`, `fab_tlast=0`, `busy=0`, `err=0`, all counters 0.
- `rst` mid-stream aborts immediately with the same reset values; any partially sent bitstream is discarded.
- Latencies:
  - `start` at edge N: `fab_cfg=1` after edge N; `s_tready` can first be high after edge N+1.
  - A byte accepted at edge M puts `fab_tvalid=1` after edge M.
- Throughput: with `s_tvalid` and `fab_tready` held high, one bit per cycle with no bubble between bytes.
- `fab_tvalid`/`fab_tdata`/`fab_tlast` stay stable while `fab_tready=0`.
- `fab_cfg_ready` seen at edge K: `fab_cfg=0` and `fab_run=1` after edge K.
- `fab_cfg_ready` is ignored outside WAIT_READY.

## Configuration

- **`CFG_TIMEOUT_EN` defined**: a counter starts at 0 on entry to WAIT_READY and increments each cycle. If `fab_cfg_ready` is still 0 when the count reaches `TIMEOUT_CYCLES`, set `err` and go to ERROR.
- **`CFG_TIMEOUT_EN` undefined**: the counter is not built, and WAIT_READY waits indefinitely.

## Test plan

- **Nominal load**: `EXPECTED_BITS=16`, bytes 0xA5 then 0x3C (last), `fab_tready=1`.
  - `fab_tdata` sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `fab_tlast` is high only on bit 16.
  - No bubble between the two bytes.
  - Raising `fab_cfg_ready` gives `fab_run=1` one cycle later.
- **Fabric backpressure**: toggle `fab_tready` 1/0 every cycle. Data stays stable during stalls, the same 16 bits come out, and all bits are delivered in 32 cycles.
- **Length error**: `s_tlast` on the first byte with `EXPECTED_BITS=16` → `err=1`, state ERROR, `fab_cfg=0`. A following `start` clears `err` and re-enters config.
- **Reconfigure from RUN**: `start` while `fab_run=1` gives `fab_run=0` and `fab_cfg=1` after the same edge, followed by a full reload.
- **Reset mid-stream**: `rst` after 5 bits → all outputs at their reset values on the next cycle. `fab_cfg_ready` pulses afterwards are ignored.
- **Timeout** (`CFG_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`): hold `fab_cfg_ready=0` → `err=1` exactly 8 cycles after entering WAIT_READY. Without the macro, the block is still in WAIT_READY after 100 cycles.
